slv_guard_cfg_seq: RTL and testbench
====================================

SLV_GUARD_CFG_SEQ -- requirements
Module: slv_guard_cfg_seq

Interface
REQ-001 SHALL have parameter NumRegs, default 11, number of guard config words to program (enable + 10 budgets).
REQ-002 SHALL have parameter BaseAddr, default 32'h0000_0000, reg-bus address of word 0.
REQ-003 SHALL have parameter MaxRetries, default 3, retries per access on reg error or timeout.
REQ-004 SHALL have parameter TimeoutCycles, default 64, max cycles valid may wait for ready.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start_i  input  1  pulse: begin programming sequence.
REQ-008 SHALL have port cfg_words_i  input  NumRegs*32  word k in bits [32k+31:32k]; word 0 written first.
REQ-009 SHALL have ports reg_addr_o output 32, reg_wdata_o output 32, reg_wstrb_o output 4, reg_write_o output 1, reg_valid_o output 1  reg-bus request.
REQ-010 SHALL have ports reg_rdata_i input 32, reg_ready_i input 1, reg_error_i input 1  reg-bus response.
REQ-011 SHALL have ports busy_o output 1, done_o output 1, err_o output 1, err_idx_o output $clog2(NumRegs+1)  status.

Function
REQ-012 SHALL implement states IDLE, WR, RD, DONE, FAIL.
REQ-013 SHALL, on start_i in IDLE, DONE or FAIL, snapshot cfg_words_i into internal register, clear index/retry/timeout counters, clear done_o/err_o, enter WR next cycle; start_i in WR/RD ignored.
REQ-014 SHALL in WR drive reg_valid_o=1, reg_write_o=1, reg_wstrb_o=4'hF, reg_addr_o=BaseAddr+4*idx, reg_wdata_o=snapshot word idx, held stable until accepted.
REQ-015 SHALL treat access complete in cycle where reg_valid_o & reg_ready_i; reg_valid_o deasserts for exactly one cycle between accesses.
REQ-016 SHALL, on complete write with reg_error_i=0, increment idx and reset retry counter; after idx NumRegs-1 go to RD with idx=0.
REQ-017 SHALL in RD drive reg_valid_o=1, reg_write_o=0, same address rule; on completion with reg_error_i=0 compare reg_rdata_i to snapshot word idx.
REQ-018 SHALL, on readback mismatch, enter FAIL with err_idx_o=idx (no retry for mismatch).
REQ-019 SHALL, after matching readback of idx NumRegs-1, enter DONE: done_o=1, busy_o=0.
REQ-020 SHALL count cycles with reg_valid_o & !reg_ready_i; reaching TimeoutCycles counts as a failed attempt, deasserting valid one cycle.
REQ-021 SHALL, on reg_error_i=1 at completion or timeout, retry same idx/op; retry counter reaching MaxRetries failures beyond first attempt -> FAIL, err_idx_o=idx.
REQ-022 SHALL in FAIL drive err_o=1, reg_valid_o=0 until next start_i or reset.
REQ-023 SHALL drive busy_o=1 exactly in WR and RD; done_o and err_o never both 1.
REQ-024 SHALL treat index arithmetic unsigned; addresses wrap modulo 2^32.

Reset
REQ-025 SHALL, while rst_n asserted, force state IDLE and all outputs 0 immediately (asynchronous), including mid-access; reg_valid_o drops without waiting for ready.
REQ-026 SHALL, after reset release, remain IDLE until start_i.

Verification
REQ-027 Nominal: NumRegs=11, words {1,0x10,0x300,0x200,0x500,0x20,0x100,1,1,1,1}, ready same cycle, echoing slave -> 11 writes at 0x00..0x28, 11 reads, done_o=1, err_o=0.
REQ-028 Error retry: reg_error_i=1 on first write to 0x08 -> write 0x08 repeated once, sequence completes, done_o=1.
REQ-029 Retry exhaustion: reg_error_i=1 on every access to 0x10 -> 4 attempts, FAIL, err_o=1, err_idx_o=4.
REQ-030 Timeout: reg_ready_i=0 for ever -> valid 64 cycles, 1-cycle gap, 4 attempts total, err_o=1, err_idx_o=0.
REQ-031 Mismatch: slave returns 0x0 for 0x04 readback -> FAIL, err_idx_o=1, no further accesses.
REQ-032 Reset mid-WR at idx 5 -> reg_valid_o=0 same cycle, all outputs 0; subsequent start_i reprograms from idx 0 to DONE.

Source files
------------

// File: rtl/slv_guard_cfg_seq_if.sv
// Register-bus bundle between the guard config sequencer (master) and a register slave.
interface slv_guard_cfg_seq_if;
    logic [31:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [3:0]  reg_wstrb_o;
    logic        reg_write_o;
    logic        reg_valid_o;
    logic [31:0] reg_rdata_i;
    logic        reg_ready_i;
    logic        reg_error_i;

    modport master (
        output reg_addr_o,
        output reg_wdata_o,
        output reg_wstrb_o,
        output reg_write_o,
        output reg_valid_o,
        input  reg_rdata_i,
        input  reg_ready_i,
        input  reg_error_i
    );

    modport slave (
        input  reg_addr_o,
        input  reg_wdata_o,
        input  reg_wstrb_o,
        input  reg_write_o,
        input  reg_valid_o,
        output reg_rdata_i,
        output reg_ready_i,
        output reg_error_i
    );
endinterface

// File: rtl/slv_guard_cfg_seq.sv
// Programs NumRegs guard config words over the register bus, reads them back to verify,
// and retries each access on bus error or timeout. rst_n is asynchronous and asserted HIGH.
module slv_guard_cfg_seq #(
    parameter int unsigned NumRegs       = 11,
    parameter logic [31:0] BaseAddr      = 32'h0000_0000,
    parameter int unsigned MaxRetries    = 3,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic [NumRegs*32-1:0]          cfg_words_i,
    slv_guard_cfg_seq_if.master            bus,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [$clog2(NumRegs+1)-1:0]   err_idx_o
);
    localparam int unsigned IdxW   = $clog2(NumRegs + 1);
    localparam int unsigned RtyW   = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam int unsigned TcW    = $clog2(TimeoutCycles + 1);
    localparam int unsigned WordsW = NumRegs * 32;

    typedef enum logic [2:0] {IDLE, WR, RD, DONE, FAIL} state_t;

    state_t            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [RtyW-1:0]   retry_q, retry_d;
    logic [TcW-1:0]    tcnt_q, tcnt_d;
    logic [WordsW-1:0] snap_q, snap_d;
    logic              valid_q, valid_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [IdxW-1:0]   err_idx_q, err_idx_d;

    logic              attempt_fail;
    logic              attempt_ok;
    logic              last_idx;
    logic [31:0]       cur_word;
    logic [31:0]       next_word;

    // Next-state, counters and registered bus/status outputs.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        tcnt_d       = tcnt_q;
        snap_d       = snap_q;
        valid_d      = 1'b0;
        done_d       = done_q;
        err_d        = err_q;
        err_idx_d    = err_idx_q;
        attempt_fail = 1'b0;
        attempt_ok   = 1'b0;
        last_idx     = (idx_q == IdxW'(NumRegs - 1));
        cur_word     = snap_q[int'(idx_q)*32 +: 32];

        unique case (state_q)
            IDLE, DONE, FAIL: begin
                if (start_i) begin
                    state_d   = WR;
                    snap_d    = cfg_words_i;
                    idx_d     = '0;
                    retry_d   = '0;
                    tcnt_d    = '0;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                    valid_d   = 1'b1;
                end
            end
            WR, RD: begin
                // A low valid here is the one-cycle gap between attempts.
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (bus.reg_ready_i) begin
                    tcnt_d = '0;
                    if (bus.reg_error_i) attempt_fail = 1'b1;
                    else                 attempt_ok   = 1'b1;
                end else if (tcnt_q == TcW'(TimeoutCycles - 1)) begin
                    tcnt_d       = '0;
                    attempt_fail = 1'b1;
                end else begin
                    tcnt_d  = tcnt_q + TcW'(1);
                    valid_d = 1'b1;
                end

                if (attempt_fail) begin
                    if (retry_q == RtyW'(MaxRetries)) begin
                        state_d   = FAIL;
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                    end else begin
                        retry_d = retry_q + RtyW'(1);
                    end
                end

                if (attempt_ok) begin
                    retry_d = '0;
                    // Readback mismatch is a data fault, not a bus fault: no retry.
                    if (state_q == RD && bus.reg_rdata_i != cur_word) begin
                        state_d   = FAIL;
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                    end else if (last_idx) begin
                        idx_d = '0;
                        if (state_q == WR) begin
                            state_d = RD;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        next_word = snap_d[int'(idx_d)*32 +: 32];
        busy_d    = (state_d == WR) || (state_d == RD);
        write_d   = (state_d == WR);
        wstrb_d   = write_d ? 4'hF : 4'h0;
        addr_d    = busy_d ? (BaseAddr + (32'(idx_d) << 2)) : 32'h0;
        wdata_d   = write_d ? next_word : 32'h0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            tcnt_q    <= '0;
            snap_q    <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            tcnt_q    <= tcnt_d;
            snap_q    <= snap_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            write_q   <= write_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign bus.reg_valid_o = valid_q;
    assign bus.reg_addr_o  = addr_q;
    assign bus.reg_wdata_o = wdata_q;
    assign bus.reg_wstrb_o = wstrb_q;
    assign bus.reg_write_o = write_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign err_idx_o       = err_idx_q;

endmodule

// File: tb/tb_slv_guard_cfg_seq.sv
// Scoreboard bench for slv_guard_cfg_seq: a reference model predicts every bus attempt and
// the final status; a register slave with error/timeout/corruption injection answers the DUT.
module tb_slv_guard_cfg_seq;
    localparam int unsigned NREGS = 11;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned MAXR  = 3;
    localparam int unsigned TMO   = 64;
    localparam int unsigned IW    = $clog2(NREGS + 1);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start_i;
    logic [NREGS*32-1:0]   cfg;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [IW-1:0]         err_idx_o;

    slv_guard_cfg_seq_if bus ();

    slv_guard_cfg_seq #(
        .NumRegs      (NREGS),
        .BaseAddr     (BASE),
        .MaxRetries   (MAXR),
        .TimeoutCycles(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .cfg_words_i(cfg),
        .bus        (bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .err_idx_o  (err_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          write;
        logic [31:0] wdata;
        bit          timeout;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_first = 1'b1;

    // Slave scenario knobs
    int          sc_max_wait;
    bit          sc_never_ready;
    int          sc_err_idx;
    bit [1:0]    sc_err_ops;      // bit0 writes, bit1 reads
    int          sc_err_n;
    int          sc_corrupt_idx;
    int          err_cnt [NREGS*2];
    logic [31:0] mem [NREGS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_scn(input int max_wait, input bit never_ready, input int e_idx,
                           input bit [1:0] e_ops, input int e_n, input int corrupt);
        sc_max_wait    = max_wait;
        sc_never_ready = never_ready;
        sc_err_idx     = e_idx;
        sc_err_ops     = e_ops;
        sc_err_n       = e_n;
        sc_corrupt_idx = corrupt;
    endtask

    function automatic bit slave_errs(input int i, input bit write, input int prior_fails);
        return (i == sc_err_idx) && sc_err_ops[write ? 0 : 1] && (prior_fails < sc_err_n);
    endfunction

    // Reference model: write pass then read pass, per-word retry budget, stop at first fault.
    task automatic build_expect(input logic [31:0] w [NREGS], output bit exp_done, output int exp_idx);
        exp_t e;
        int   fails;
        bit   ok;
        exp_done = 1'b1;
        exp_idx  = 0;
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < NREGS; i++) begin
                fails = 0;
                ok    = 1'b0;
                while (!ok) begin
                    e.addr    = BASE + 32'(4 * i);
                    e.write   = (op == 0);
                    e.wdata   = w[i];
                    e.timeout = sc_never_ready;
                    exp_q.push_back(e);
                    if (sc_never_ready || slave_errs(i, op == 0, fails)) begin
                        fails++;
                        if (fails > int'(MAXR)) begin
                            exp_done = 1'b0;
                            exp_idx  = i;
                            return;
                        end
                    end else begin
                        ok = 1'b1;
                    end
                end
                if (op == 1 && i == sc_corrupt_idx && w[i] != 32'h0) begin
                    exp_done = 1'b0;
                    exp_idx  = i;
                    return;
                end
            end
        end
    endtask

    // Register slave: random wait states, error injection, echo memory, optional corruption.
    initial begin : slave
        bit prev;
        int wait_left;
        int i;
        int key;
        prev = 1'b0;
        wait_left = 0;
        bus.reg_ready_i = 1'b0;
        bus.reg_error_i = 1'b0;
        bus.reg_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.reg_ready_i = 1'b0;
            bus.reg_error_i = 1'b0;
            bus.reg_rdata_i = 32'h0;
            if (bus.reg_valid_o === 1'b1) begin
                if (!prev) wait_left = (sc_max_wait == 0) ? 0 : int'($urandom_range(0, sc_max_wait));
                if (sc_never_ready) begin
                    wait_left = 0;
                end else if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    i   = int'((bus.reg_addr_o - BASE) >> 2);
                    key = i * 2 + (bus.reg_write_o ? 0 : 1);
                    bus.reg_ready_i = 1'b1;
                    if (i >= 0 && i < NREGS) begin
                        if (slave_errs(i, bus.reg_write_o, err_cnt[key])) begin
                            bus.reg_error_i = 1'b1;
                            err_cnt[key]++;
                        end else if (bus.reg_write_o) begin
                            mem[i] = bus.reg_wdata_o;
                        end else begin
                            bus.reg_rdata_i = (i == sc_corrupt_idx) ? 32'h0 : mem[i];
                        end
                    end
                end
            end
            prev = (bus.reg_valid_o === 1'b1);
        end
    end

    // Monitor: each rising valid is one attempt, popped from the scoreboard and compared.
    initial begin : monitor
        bit          prev;
        int          hold;
        int          gap;
        bit          cur_to;
        logic [31:0] h_addr;
        logic [31:0] h_wdata;
        exp_t        e;
        prev = 1'b0; hold = 0; gap = 0; cur_to = 1'b0; h_addr = '0; h_wdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                prev = 1'b0; hold = 0; cur_to = 1'b0;
            end else begin
                if (bus.reg_valid_o && !prev) begin
                    if (!mon_first) chk("gap before access", 32'(gap), 32'd1);
                    mon_first = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        cur_to = 1'b0;
                        $display("FAIL unexpected access: addr 0x%0h write %0d, expected no access",
                                 bus.reg_addr_o, bus.reg_write_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("access addr", bus.reg_addr_o, e.addr);
                        chk("access write", 32'(bus.reg_write_o), 32'(e.write));
                        if (e.write) begin
                            chk("access wdata", bus.reg_wdata_o, e.wdata);
                            chk("access wstrb", 32'(bus.reg_wstrb_o), 32'hF);
                        end
                        chk("busy during access", 32'(busy_o), 32'd1);
                        cur_to = e.timeout;
                    end
                    hold = 0;
                    h_addr = bus.reg_addr_o;
                    h_wdata = bus.reg_wdata_o;
                end else if (bus.reg_valid_o) begin
                    chk("request stable", 32'(bus.reg_addr_o == h_addr && bus.reg_wdata_o == h_wdata), 32'd1);
                end
                if (bus.reg_valid_o) begin
                    hold++;
                    gap = 0;
                end else begin
                    if (prev && cur_to) chk("timeout valid length", 32'(hold), 32'(TMO));
                    gap++;
                end
                prev = bus.reg_valid_o;
            end
        end
    end

    bit exp_done_g;
    int exp_idx_g;

    task automatic launch();
        logic [31:0] w [NREGS];
        for (int i = 0; i < NREGS; i++) w[i] = cfg[32*i +: 32];
        exp_q.delete();
        for (int k = 0; k < NREGS*2; k++) err_cnt[k] = 0;
        build_expect(w, exp_done_g, exp_idx_g);
        mon_first = 1'b1;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run(input string tag, input bit mid_start);
        bit seen;
        launch();
        seen = 1'b0;
        for (int cyc = 0; cyc < 4000 && !seen; cyc++) begin
            if (mid_start && cyc == 6 && busy_o) begin
                for (int i = 0; i < NREGS; i++) cfg[32*i +: 32] = $urandom;
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end else begin
                @(negedge clk);
            end
            seen = done_o || err_o;
        end
        chk({tag, " finished"}, 32'(seen), 32'd1);
        repeat (4) @(negedge clk);
        chk({tag, " pending attempts"}, 32'(exp_q.size()), 32'd0);
        chk({tag, " done"}, 32'(done_o), 32'(exp_done_g));
        chk({tag, " err"}, 32'(err_o), 32'(!exp_done_g));
        if (!exp_done_g) chk({tag, " err_idx"}, 32'(err_idx_o), 32'(exp_idx_g));
        chk({tag, " busy idle"}, 32'(busy_o), 32'd0);
        chk({tag, " valid idle"}, 32'(bus.reg_valid_o), 32'd0);
    endtask

    task automatic load_nominal();
        logic [31:0] nom [NREGS];
        nom = '{32'h1, 32'h10, 32'h300, 32'h200, 32'h500, 32'h20, 32'h100, 32'h1, 32'h1, 32'h1, 32'h1};
        for (int i = 0; i < NREGS; i++) cfg[32*i +: 32] = nom[i];
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit found;
        rst_n   = 1'b1;
        start_i = 1'b0;
        cfg     = '0;
        set_scn(0, 1'b0, -1, 2'b00, 0, -1);
        repeat (2) @(negedge clk);
        chk("reset valid", 32'(bus.reg_valid_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        chk("reset err_idx", 32'(err_idx_o), 32'd0);
        chk("reset addr", bus.reg_addr_o, 32'd0);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle after release valid", 32'(bus.reg_valid_o), 32'd0);
        chk("idle after release busy", 32'(busy_o), 32'd0);

        load_nominal();
        set_scn(0, 1'b0, -1, 2'b00, 0, -1);
        run("nominal", 1'b0);

        set_scn(0, 1'b0, 2, 2'b01, 1, -1);
        run("write error retry", 1'b0);

        set_scn(0, 1'b0, 4, 2'b11, 99, -1);
        run("retry exhaustion", 1'b0);

        set_scn(0, 1'b1, -1, 2'b00, 0, -1);
        run("timeout", 1'b0);

        set_scn(0, 1'b0, -1, 2'b00, 0, 1);
        run("readback mismatch", 1'b0);

        // Reset in the middle of the write to word 5, then reprogram from scratch.
        set_scn(0, 1'b0, -1, 2'b00, 0, -1);
        load_nominal();
        launch();
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (bus.reg_valid_o && bus.reg_write_o && bus.reg_addr_o == BASE + 32'h14) found = 1'b1;
            else @(negedge clk);
        end
        chk("reached write idx5", 32'(found), 32'd1);
        #2 rst_n = 1'b1;
        #1;
        chk("mid reset valid", 32'(bus.reg_valid_o), 32'd0);
        chk("mid reset write", 32'(bus.reg_write_o), 32'd0);
        chk("mid reset addr", bus.reg_addr_o, 32'd0);
        chk("mid reset wdata", bus.reg_wdata_o, 32'd0);
        chk("mid reset wstrb", 32'(bus.reg_wstrb_o), 32'd0);
        chk("mid reset busy", 32'(busy_o), 32'd0);
        chk("mid reset done", 32'(done_o), 32'd0);
        chk("mid reset err", 32'(err_o), 32'd0);
        chk("mid reset err_idx", 32'(err_idx_o), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        run("rerun after reset", 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREGS; i++) cfg[32*i +: 32] = $urandom;
            set_scn(int'($urandom_range(0, 3)), 1'b0, int'($urandom_range(0, NREGS - 1)),
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1)) : -1);
            run("random", (r % 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
